// File: rtl/combi_encoder.sv
`default_nettype none
// ============================================================================
// Module   : combi_encoder
// Purpose  : Encodes op records into ARM / RISC-V words, FIFO-buffered, with a
//            streaming write address. Option macro: ENC_ISA_NOP_EN.
// Revision : 1.0
// ============================================================================
module combi_encoder #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ADDR_W    = 32,
    parameter bit          RESET_ISA = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_isa,
    input  logic [2:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_arm,
    input  logic              base_load,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              err,
    output logic [7:0]        err_cnt
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [2:0]  c_OP_ADD   = 3'd0;
    localparam logic [2:0]  c_OP_SUB   = 3'd1;
    localparam logic [2:0]  c_OP_AND   = 3'd2;
    localparam logic [2:0]  c_OP_OR    = 3'd3;
    localparam logic [2:0]  c_OP_ADDI  = 3'd4;
    localparam logic [2:0]  c_OP_LOAD  = 3'd5;
    localparam logic [2:0]  c_OP_STORE = 3'd6;
    localparam logic [31:0] c_ARM_NOP  = 32'hE280_0000;
    localparam logic [31:0] c_RV_NOP   = 32'h0000_0013;

    logic [31:0] w_enc_word;
    logic        w_enc_ok;
    logic [3:0]  w_arm_cmd;
    logic [6:0]  w_rv_f7;
    logic [2:0]  w_rv_f3;
    logic        w_imm_s12;
    logic        w_imm_s13;
    logic        w_imm_s26;

    // Sign-extension checks: the upper bits must all match the field's sign bit
    assign w_imm_s12 = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
    assign w_imm_s13 = (in_imm[31:12] == '0) || (in_imm[31:12] == '1);
    assign w_imm_s26 = (in_imm[31:25] == '0) || (in_imm[31:25] == '1);

    always_comb begin
        w_arm_cmd = 4'b0100;
        w_rv_f7   = 7'b0000000;
        w_rv_f3   = 3'b000;
        case (in_op)
            c_OP_SUB: begin
                w_arm_cmd = 4'b0010;
                w_rv_f7   = 7'b0100000;
            end
            c_OP_AND: begin
                w_arm_cmd = 4'b0000;
                w_rv_f3   = 3'b111;
            end
            c_OP_OR: begin
                w_arm_cmd = 4'b1100;
                w_rv_f3   = 3'b110;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_enc_word = '0;
        w_enc_ok   = 1'b1;
        if (in_isa) begin
            case (in_op)
                c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR: begin
                    w_enc_word = {4'hE, 2'b00, 1'b0, w_arm_cmd, 1'b0, in_rs1[3:0],
                                  in_rd[3:0], 8'h00, in_rs2[3:0]};
                    w_enc_ok   = !(in_rd[4] | in_rs1[4] | in_rs2[4]);
                end
                c_OP_ADDI: begin
                    w_enc_word = {4'hE, 2'b00, 1'b1, 4'b0100, 1'b0, in_rs1[3:0],
                                  in_rd[3:0], 4'h0, in_imm[7:0]};
                    w_enc_ok   = !(in_rd[4] | in_rs1[4]) && (in_imm[31:8] == '0);
                end
                c_OP_LOAD: begin
                    w_enc_word = {4'hE, 2'b01, 6'b011001, in_rs1[3:0], in_rd[3:0],
                                  in_imm[11:0]};
                    w_enc_ok   = !(in_rd[4] | in_rs1[4]) && (in_imm[31:12] == '0);
                end
                c_OP_STORE: begin
                    w_enc_word = {4'hE, 2'b01, 6'b011000, in_rs1[3:0], in_rs2[3:0],
                                  in_imm[11:0]};
                    w_enc_ok   = !(in_rs1[4] | in_rs2[4]) && (in_imm[31:12] == '0);
                end
                default: begin
                    w_enc_word = {4'hE, 3'b101, 1'b0, in_imm[25:2]};
                    w_enc_ok   = (in_imm[1:0] == 2'b00) && w_imm_s26;
                end
            endcase
        end else begin
            case (in_op)
                c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR: begin
                    w_enc_word = {w_rv_f7, in_rs2, in_rs1, w_rv_f3, in_rd, 7'b0110011};
                end
                c_OP_ADDI: begin
                    w_enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b0010011};
                    w_enc_ok   = w_imm_s12;
                end
                c_OP_LOAD: begin
                    w_enc_word = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
                    w_enc_ok   = w_imm_s12;
                end
                c_OP_STORE: begin
                    w_enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0],
                                  7'b0100011};
                    w_enc_ok   = w_imm_s12;
                end
                default: begin
                    w_enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                                  in_imm[4:1], in_imm[11], 7'b1100011};
                    w_enc_ok   = !in_imm[0] && w_imm_s13;
                end
            endcase
        end
    end

    logic [32:0]       mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, wr_ptr_nx;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic              err_q;
    logic [7:0]        err_cnt_q;
    logic              w_accept;
    logic              w_push;
    logic              w_push_nop;
    logic              w_pop;

    assign w_accept  = in_valid & in_ready;
    assign w_push    = w_accept & w_enc_ok;
    assign w_pop     = out_valid & out_ready;
    assign wr_ptr_nx = wr_ptr_q + PTR_W'(1);

`ifdef ENC_ISA_NOP_EN
    logic last_isa_q;
    logic w_need_nop;

    // An ISA switch costs two slots (NOP + op), so readiness depends on in_isa
    assign w_need_nop = (in_isa != last_isa_q);
    assign in_ready   = w_need_nop ? (cnt_q <= CNT_W'(DEPTH - 2))
                                   : (cnt_q <= CNT_W'(DEPTH - 1));
    assign w_push_nop = w_push & w_need_nop;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_isa_q <= RESET_ISA;
        end else if (w_push) begin
            last_isa_q <= in_isa;
        end
    end
`else
    assign in_ready   = (cnt_q <= CNT_W'(DEPTH - 1));
    assign w_push_nop = 1'b0;
`endif

    always_comb begin
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        if (w_push) begin
            cnt_d    = cnt_q + (w_push_nop ? CNT_W'(2) : CNT_W'(1));
            wr_ptr_d = wr_ptr_q + (w_push_nop ? PTR_W'(2) : PTR_W'(1));
        end
        if (w_pop) begin
            cnt_d = cnt_d - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {RESET_ISA, 32'h0};
            end
        end else if (w_push) begin
            if (w_push_nop) begin
                mem_q[wr_ptr_q]  <= {in_isa, in_isa ? c_ARM_NOP : c_RV_NOP};
                mem_q[wr_ptr_nx] <= {in_isa, w_enc_word};
            end else begin
                mem_q[wr_ptr_q]  <= {in_isa, w_enc_word};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            addr_q    <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            // The address is bound at pop time, so a reload only affects later words
            if (base_load) begin
                addr_q <= base_addr;
            end else if (w_pop) begin
                addr_q <= addr_q + ADDR_W'(4);
            end
            err_q <= w_accept & ~w_enc_ok;
            if (w_accept && !w_enc_ok && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign out_valid = (cnt_q != '0);
    assign out_instr = mem_q[rd_ptr_q][31:0];
    assign out_arm   = mem_q[rd_ptr_q][32];
    assign out_addr  = addr_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_combi_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_combi_encoder
// Purpose  : Directed vectors with hand-computed words for combi_encoder.
// Revision : 1.0
// ============================================================================
module tb_combi_encoder;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 32;

    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3;
    localparam logic [2:0] OP_ADDI = 3'd4, OP_LOAD = 3'd5, OP_STORE = 3'd6, OP_BR = 3'd7;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              in_valid;
    logic              in_ready;
    logic              in_isa;
    logic [2:0]        in_op;
    logic [4:0]        in_rd, in_rs1, in_rs2;
    logic [31:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              out_arm;
    logic              base_load;
    logic [ADDR_W-1:0] base_addr;
    logic              err;
    logic [7:0]        err_cnt;

    int                n_total = 0;
    int                n_bad   = 0;
    logic [32:0]       exp_q[$];
    logic [32:0]       mon_e;
    logic [ADDR_W-1:0] addr_m = '0;
    int                errc_m = 0;
    bit                last_m = 1'b0;

    always #5 clk = ~clk;

    combi_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_ISA(1'b0)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_isa(in_isa), .in_op(in_op),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .out_arm(out_arm),
        .base_load(base_load), .base_addr(base_addr),
        .err(err), .err_cnt(err_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every handshake must match the oldest expected word
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            addr_m = '0;
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_pop", out_instr, 32'h0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("instr", out_instr, mon_e[31:0]);
                    check("arm", {31'b0, out_arm}, {31'b0, mon_e[32]});
                    check("addr", out_addr, addr_m);
                end
            end
            if (base_load) addr_m = base_addr;
            else if (out_valid && out_ready) addr_m = addr_m + 32'd4;
        end
    end

    task automatic send(input bit isa, input logic [2:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic [31:0] exp_w, input bit exp_ok);
        int waited;
        in_isa = isa; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_valid = 1'b1;
        waited = 0;
        while (!in_ready && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            check("ready_timeout", {31'b0, in_ready}, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (exp_ok) begin
`ifdef ENC_ISA_NOP_EN
            if (isa != last_m) exp_q.push_back({isa, isa ? 32'hE280_0000 : 32'h0000_0013});
            last_m = isa;
`endif
            exp_q.push_back({isa, exp_w});
        end else if (errc_m < 255) begin
            errc_m++;
        end
        check("err", {31'b0, err}, {31'b0, !exp_ok});
        check("err_cnt", {24'b0, err_cnt}, errc_m);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_left", exp_q.size(), 32'd0);
        check("drain_valid", {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_isa = 1'b0; in_op = '0; in_rd = '0;
        in_rs1 = '0; in_rs2 = '0; in_imm = '0; out_ready = 1'b0; base_load = 1'b0;
        base_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_instr", out_instr, 32'h0);
        check("rst_addr", out_addr, 32'h0);
        check("rst_arm", {31'b0, out_arm}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_err_cnt", {24'b0, err_cnt}, 32'd0);
        reset_n = 1'b1;
        check("rst_ready", {31'b0, in_ready}, 32'd1);

        // First ARM op straight after reset
        out_ready = 1'b1;
        send(1, OP_ADD, 5'd1, 5'd2, 5'd3, 32'd0, 32'hE082_1003, 1);
        check("lat_valid", {31'b0, out_valid}, 32'd1);
`ifdef ENC_ISA_NOP_EN
        check("lat_instr", out_instr, 32'hE280_0000);
`else
        check("lat_instr", out_instr, 32'hE082_1003);
`endif
        check("lat_addr", out_addr, 32'h0);
        check("lat_arm", {31'b0, out_arm}, 32'd1);
        wait_drain();

        // RISC-V encodings
        send(0, OP_ADD,   5'd1, 5'd2, 5'd3, 32'd0,         32'h0031_00B3, 1);
        send(0, OP_ADDI,  5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFF0_0293, 1);
        send(0, OP_STORE, 5'd0, 5'd7, 5'd6, 32'd12,        32'h0063_A623, 1);
        send(0, OP_BR,    5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'hFE20_8EE3, 1);
        // ARM encodings
        send(1, OP_BR,    5'd0, 5'd0, 5'd0, 32'hFFFF_FFF8, 32'hEAFF_FFFE, 1);
        send(1, OP_LOAD,  5'd4, 5'd5, 5'd0, 32'd8,         32'hE595_4008, 1);
        send(1, OP_SUB,   5'd1, 5'd2, 5'd3, 32'd0,         32'hE042_1003, 1);
        send(1, OP_OR,    5'd4, 5'd5, 5'd6, 32'd0,         32'hE185_4006, 1);
        send(1, OP_AND,   5'd0, 5'd1, 5'd2, 32'd0,         32'hE001_0002, 1);
        send(1, OP_ADDI,  5'd2, 5'd3, 5'd0, 32'd255,       32'hE283_20FF, 1);
        send(1, OP_STORE, 5'd0, 5'd1, 5'd2, 32'd4095,      32'hE581_2FFF, 1);
        send(1, OP_BR,    5'd0, 5'd0, 5'd0, 32'd8,         32'hEA00_0002, 1);
        // More RISC-V, including immediate boundaries
        send(0, OP_SUB,   5'd1, 5'd2, 5'd3, 32'd0,         32'h4031_00B3, 1);
        send(0, OP_AND,   5'd1, 5'd2, 5'd3, 32'd0,         32'h0031_70B3, 1);
        send(0, OP_OR,    5'd1, 5'd2, 5'd3, 32'd0,         32'h0031_60B3, 1);
        send(0, OP_LOAD,  5'd5, 5'd6, 5'd0, 32'd2047,      32'h7FF3_2283, 1);
        send(0, OP_BR,    5'd0, 5'd3, 5'd4, 32'd4094,      32'h7E41_8FE3, 1);
        send(0, OP_ADDI,  5'd1, 5'd1, 5'd0, 32'hFFFF_F800, 32'h8000_8093, 1);
        wait_drain();

        // Unencodable ops
        send(1, OP_ADDI, 5'd2, 5'd3, 5'd0, 32'd256,  32'h0, 0);
        send(0, OP_ADDI, 5'd1, 5'd1, 5'd0, 32'd2048, 32'h0, 0);
        check("err_cnt_two", {24'b0, err_cnt}, 32'd2);
        @(posedge clk); #1;
        check("err_pulse_end", {31'b0, err}, 32'd0);
        send(1, OP_ADD,   5'd16, 5'd2, 5'd3, 32'd0,         32'h0, 0);
        send(1, OP_BR,    5'd0,  5'd0, 5'd0, 32'd2,         32'h0, 0);
        send(1, OP_BR,    5'd0,  5'd0, 5'd0, 32'h0200_0000, 32'h0, 0);
        send(1, OP_LOAD,  5'd1,  5'd2, 5'd0, 32'hFFFF_FFFF, 32'h0, 0);
        send(0, OP_BR,    5'd0,  5'd1, 5'd2, 32'd4096,      32'h0, 0);
        send(0, OP_BR,    5'd0,  5'd1, 5'd2, 32'd3,         32'h0, 0);
        send(0, OP_STORE, 5'd0,  5'd1, 5'd2, 32'hFFFF_F7FF, 32'h0, 0);
        for (int i = 0; i < 300; i++) begin
            send(1, OP_ADDI, 5'd1, 5'd1, 5'd0, 32'd256, 32'h0, 0);
        end
        check("err_cnt_sat", {24'b0, err_cnt}, 32'd255);
        check("bad_no_output", {31'b0, out_valid}, 32'd0);

        // Back-pressure: fill, check stall and hold, then drain with a reload
        out_ready = 1'b0;
        send(0, OP_ADD, 5'd1, 5'd2, 5'd3, 32'd0, 32'h0031_00B3, 1);
        send(0, OP_SUB, 5'd1, 5'd2, 5'd3, 32'd0, 32'h4031_00B3, 1);
        send(0, OP_AND, 5'd1, 5'd2, 5'd3, 32'd0, 32'h0031_70B3, 1);
        send(0, OP_OR,  5'd1, 5'd2, 5'd3, 32'd0, 32'h0031_60B3, 1);
        in_isa = 1'b0; in_op = OP_ADDI; in_rd = 5'd5; in_rs1 = 5'd0; in_imm = 32'hFFFF_FFFF;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("full_ready", {31'b0, in_ready}, 32'd0);
            check("hold_valid", {31'b0, out_valid}, 32'd1);
            check("hold_instr", out_instr, 32'h0031_00B3);
        end
        out_ready = 1'b1;
        send(0, OP_ADDI, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFF0_0293, 1);
        base_load = 1'b1;
        base_addr = 32'h0000_0100;
        @(posedge clk); #1;
        base_load = 1'b0;
        wait_drain();

        // Reset with words queued: nothing must come out afterwards
        out_ready = 1'b0;
        send(0, OP_ADD,  5'd1, 5'd2, 5'd3, 32'd0,    32'h0031_00B3, 1);
        send(0, OP_LOAD, 5'd5, 5'd6, 5'd0, 32'd2047, 32'h7FF3_2283, 1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_addr", out_addr, 32'h0);
        check("mid_rst_err_cnt", {24'b0, err_cnt}, 32'd0);
        reset_n = 1'b1;
        errc_m = 0;
        last_m = 1'b0;
        out_ready = 1'b1;
        send(0, OP_ADD, 5'd1, 5'd2, 5'd3, 32'd0, 32'h0031_00B3, 1);
        check("post_rst_addr", out_addr, 32'h0);
        wait_drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
